// File: rtl/ex_muldiv_seq_if.sv
// Handshake bundle between the execute stage and the multi-cycle RV32M sequencer.
// The pipeline drives the request side; the sequencer drives stall/done/y back.
interface ex_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            pipe_flush;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] y;

  modport master (
    output pipe_flush, start, op, a, b,
    input  stall, done, y
  );

  modport slave (
    input  pipe_flush, start, op, a, b,
    output stall, done, y
  );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Multi-cycle RV32M unit: shift-add multiply and restoring divide on operand magnitudes,
// one iteration per cycle, result presented for a single cycle with the pipeline released.
module ex_muldiv_seq #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  ex_muldiv_seq_if.slave bus
);

  localparam int         CW       = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULHU = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic              bz_q, bz_d;
  logic [XLEN-1:0]   bmag_q, bmag_d;
  logic [2*XLEN:0]   acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   y_q, y_d;

  logic              stall;
  logic              a_sgn, b_sgn, b_zero, ovf, early;
  logic [XLEN-1:0]   early_y;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return '0 - v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return '0 - v;
  endfunction

  // acc = {carry+high partial product, remaining multiplier bits}; shifts right once per step.
  function automatic logic [2*XLEN:0] mul_step(input logic [2*XLEN:0] acc,
                                               input logic [XLEN-1:0] m);
    logic [XLEN:0] sum;
    sum = acc[2*XLEN:XLEN] + (acc[0] ? {1'b0, m} : '0);
    return {1'b0, sum, acc[XLEN-1:1]};
  endfunction

  // acc = {partial remainder (XLEN+1), dividend bits shifting out / quotient bits shifting in}.
  function automatic logic [2*XLEN:0] div_step(input logic [2*XLEN:0] acc,
                                               input logic [XLEN-1:0] d);
    logic [XLEN:0]   rs;
    logic [XLEN+1:0] trial;
    rs    = acc[2*XLEN-1:XLEN-1];
    trial = {1'b0, rs} - {2'b00, d};
    if (!trial[XLEN+1]) begin
      return {trial[XLEN:0], acc[XLEN-2:0], 1'b1};
    end
    return {rs, acc[XLEN-2:0], 1'b0};
  endfunction

  // Divide-by-zero leaves quotient magnitude all ones and remainder = |a|, so only the
  // quotient needs forcing; the remainder re-signs back to a.
  function automatic logic [XLEN-1:0] finish_res(input logic [2:0]      op,
                                                 input logic            sa,
                                                 input logic            sb,
                                                 input logic            bz,
                                                 input logic [2*XLEN:0] acc);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    prod = (sa ^ sb) ? neg_2x(acc[2*XLEN-1:0]) : acc[2*XLEN-1:0];
    quo  = bz ? '1 : ((sa ^ sb) ? neg_x(acc[XLEN-1:0]) : acc[XLEN-1:0]);
    rem  = sa ? neg_x(acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
    if (!op[2]) begin
      return (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
    return op[1] ? rem : quo;
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    bmag_d  = bmag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    y_d     = y_q;
    stall   = 1'b0;

    a_sgn   = bus.a[XLEN-1] & (bus.op[2] ? ~bus.op[0] : (bus.op != OP_MULHU));
    b_sgn   = bus.b[XLEN-1] & (bus.op[2] ? ~bus.op[0] : ~bus.op[1]);
    b_zero  = (bus.b == '0);
    ovf     = ~bus.op[0] & (bus.a == {1'b1, {(XLEN-1){1'b0}}}) & (bus.b == '1);
    early   = EARLY_OUT & bus.op[2] & (b_zero | ovf);
    early_y = bus.op[1] ? (b_zero ? bus.a : '0) : (b_zero ? '1 : bus.a);

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.pipe_flush) begin
          stall  = 1'b1;
          op_d   = bus.op;
          sa_d   = a_sgn;
          sb_d   = b_sgn;
          bz_d   = b_zero;
          bmag_d = b_sgn ? neg_x(bus.b) : bus.b;
          acc_d  = {{(XLEN+1){1'b0}}, (a_sgn ? neg_x(bus.a) : bus.a)};
          cnt_d  = CW'(XLEN-1);
          if (early) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            y_d     = early_y;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        stall = 1'b1;
        acc_d = op_q[2] ? div_step(acc_q, bmag_q) : mul_step(acc_q, bmag_q);
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          y_d     = finish_res(op_q, sa_q, sb_q, bz_q, acc_d);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Flush abandons the operation without touching the last presented result.
    if (bus.pipe_flush) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      y_d     = y_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      bmag_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      bmag_q  <= bmag_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      y_q     <= y_d;
    end
  end

  assign bus.stall = stall;
  assign bus.done  = done_q;
  assign bus.y     = y_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Scoreboard bench: an early-out and a full-loop instance see identical stimulus;
// expected results and completion cycles are queued at issue and checked on done.
module tb_ex_muldiv_seq;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_seq_if #(.XLEN(XLEN)) bus0 ();
  ex_muldiv_seq_if #(.XLEN(XLEN)) bus1 ();

  ex_muldiv_seq #(.XLEN(XLEN), .EARLY_OUT(1'b1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  ex_muldiv_seq #(.XLEN(XLEN), .EARLY_OUT(1'b0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;
  logic [31:0] last_exp = '0;

  logic [31:0] y0q[$];
  logic [31:0] y1q[$];
  int          c0q[$];
  int          c1q[$];
  string       t0q[$];
  string       t1q[$];

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    bus0.start = st; bus0.pipe_flush = fl; bus0.op = op; bus0.a = a; bus0.b = b;
    bus1.start = st; bus1.pipe_flush = fl; bus1.op = op; bus1.a = a; bus1.b = b;
  endtask

  function automatic logic is_early(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ae, be, p;
    logic        ovf;
    ae  = (op == 3'd3) ? {32'h0, a} : {{32{a[31]}}, a};
    be  = (op == 3'd2 || op == 3'd3) ? {32'h0, b} : {{32{b[31]}}, b};
    p   = ae * be;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0:    return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
      3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6:    return (b == 0) ? a : (ovf ? 32'h0 : 32'($signed(a) % $signed(b)));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitors sample 2 ns after the active edge.
  always @(posedge clk) begin
    #2;
    if (c0q.size() > 0) begin
      if (ecnt == c0q[0]) begin
        chk({t0q[0], "/e1_done"}, 32'(bus0.done), 32'd1);
        chk({t0q[0], "/e1_y"}, bus0.y, y0q[0]);
        chk({t0q[0], "/e1_stall_done"}, 32'(bus0.stall), 32'd0);
        void'(c0q.pop_front()); void'(y0q.pop_front()); void'(t0q.pop_front());
      end else begin
        chk({t0q[0], "/e1_busy_done"}, 32'(bus0.done), 32'd0);
        chk({t0q[0], "/e1_busy_stall"}, 32'(bus0.stall), 32'd1);
      end
    end else begin
      chk("e1_idle_done", 32'(bus0.done), 32'd0);
    end
  end

  always @(posedge clk) begin
    #2;
    if (c1q.size() > 0) begin
      if (ecnt == c1q[0]) begin
        chk({t1q[0], "/e0_done"}, 32'(bus1.done), 32'd1);
        chk({t1q[0], "/e0_y"}, bus1.y, y1q[0]);
        chk({t1q[0], "/e0_stall_done"}, 32'(bus1.stall), 32'd0);
        void'(c1q.pop_front()); void'(y1q.pop_front()); void'(t1q.pop_front());
      end else begin
        chk({t1q[0], "/e0_busy_done"}, 32'(bus1.done), 32'd0);
        chk({t1q[0], "/e0_busy_stall"}, 32'(bus1.stall), 32'd1);
      end
    end else begin
      chk("e0_idle_done", 32'(bus1.done), 32'd0);
    end
  end

  task automatic clear_q();
    c0q.delete(); y0q.delete(); t0q.delete();
    c1q.delete(); y1q.delete(); t1q.delete();
  endtask

  task automatic push_exp(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    t0q.push_back(tag); y0q.push_back(exp); c0q.push_back(ecnt + 1 + (is_early(op, a, b) ? 0 : 32));
    t1q.push_back(tag); y1q.push_back(exp); c1q.push_back(ecnt + 1 + 32);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (c0q.size() == 0 && c1q.size() == 0) break;
      @(posedge clk); #3;
    end
    if (c0q.size() != 0 || c1q.size() != 0) begin
      chk({tag, "/drain_timeout"}, 32'(c0q.size() + c1q.size()), 32'd0);
      clear_q();
    end
  endtask

  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input logic hold);
    @(negedge clk);
    drive(1'b1, 1'b0, op, a, b);
    push_exp(tag, op, a, b, exp);
    last_exp = exp;
    #1;
    chk({tag, "/e1_stall_start"}, 32'(bus0.stall), 32'd1);
    chk({tag, "/e0_stall_start"}, 32'(bus1.stall), 32'd1);
    @(negedge clk);
    if (!hold) drive(1'b0, 1'b0, 3'($urandom), $urandom, $urandom);
    drain(tag);
    @(negedge clk);
    if (hold) begin
      #1;
      chk({tag, "/e1_done_ignores_start"}, 32'(bus0.stall), 32'd0);
      chk({tag, "/e0_done_ignores_start"}, 32'(bus1.stall), 32'd0);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_e1_done", 32'(bus0.done), 32'd0);
    chk("rst_e1_y", bus0.y, 32'h0);
    chk("rst_e1_stall", 32'(bus0.stall), 32'd0);
    chk("rst_e0_y", bus1.y, 32'h0);
    rst_n = 1'b1;

    issue("mul_neg",   3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    issue("mulhu_m1",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    issue("mulh_m1",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    issue("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 1'b0);
    issue("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    issue("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    issue("divu_z",    3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 1'b0);
    issue("remu_z",    3'd7, 32'd5,          32'd0,          32'd5,         1'b0);
    issue("div_z_neg", 3'd4, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFF, 1'b0);
    issue("rem_z_neg", 3'd6, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 1'b0);
    issue("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 1'b0);
    issue("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 1'b0);
    issue("divu_100",  3'd5, 32'd100,        32'd7,          32'd14,        1'b0);
    issue("remu_100",  3'd7, 32'd100,        32'd7,          32'd2,         1'b0);

    // Flush ten cycles into a divide: no result, y unchanged.
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd4, 32'd1000, 32'd3);
    push_exp("div_flushed", 3'd4, 32'd1000, 32'd3, 32'd333);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd4, 32'd0, 32'd0);
    repeat (9) @(negedge clk);
    drive(1'b1, 1'b1, 3'd0, 32'd0, 32'd0);
    clear_q();
    @(posedge clk); #2;
    chk("flush_e1_stall", 32'(bus0.stall), 32'd0);
    chk("flush_e0_stall", 32'(bus1.stall), 32'd0);
    chk("flush_e1_y_kept", bus0.y, last_exp);
    chk("flush_e0_y_kept", bus1.y, last_exp);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (40) @(negedge clk);
    issue("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12, 1'b0);

    // Flush in the same cycle as start: nothing begins.
    @(negedge clk);
    drive(1'b1, 1'b1, 3'd0, 32'd5, 32'd6);
    #1;
    chk("flush_start_e1_stall", 32'(bus0.stall), 32'd0);
    chk("flush_start_e0_stall", 32'(bus1.stall), 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    issue("mul_after_fs", 3'd0, 32'd6, 32'd7, 32'd42, 1'b0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd0, 32'd9, 32'd9);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 3'd5, 32'd50, 32'd5);
    @(posedge clk); #2;
    chk("rstrun_e1_done", 32'(bus0.done), 32'd0);
    chk("rstrun_e1_y", bus0.y, 32'h0);
    chk("rstrun_e1_stall", 32'(bus0.stall), 32'd1);
    chk("rstrun_e0_y", bus1.y, 32'h0);
    chk("rstrun_e0_stall", 32'(bus1.stall), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    #1;
    chk("rstrun_e1_idle_stall", 32'(bus0.stall), 32'd0);
    repeat (40) @(negedge clk);
    issue("divu_after_rst", 3'd5, 32'd50, 32'd5, 32'd10, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      issue($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, model(rop, ra, rb), 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
